rtc_snapshot_master: RTL and testbench

Wishbone initiator that drives the real-time clock core's 3-bit register bus from the host side. On request it issues one single-register write, or a pipelined burst read of RTC registers 0..4 (clock, timer, stopwatch, alarm, ckspeed). Burst results land in a shadow buffer and are published atomically as one coherent snapshot. It sits between a CPU/sequencer and the RTC, with a timeout guarding against a non-responding bus.

---
 rtl/rtc_snapshot_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_rtc_snapshot_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_snapshot_master.sv
// rtc_snapshot_master
// -------------------
// Wishbone initiator for the RTC core's 3-bit register bus. On i_wr_req it
// issues one single-register write. On i_snap it issues a pipelined burst read
// of registers 0..NREGS-1 into a shadow buffer. The shadow buffer is published
// to the snapshot outputs in one edge, so the outputs always come from one
// coherent burst. A timeout aborts any transaction whose slave stops acking.
//
// Optional feature macro: RTCSNAP_HACK_EN
//   defined   : burst length forced to 8; o_hack_time = reg5[29:0] and
//               o_hack_counter = {reg6, reg7[31:24]} are published with o_valid.
//   undefined : 5-register burst; hack ports absent.
//
// Ports:
//   i_clk, i_reset_n         clock, synchronous active-low reset
//   i_snap                   pulse: start a snapshot burst read
//   i_wr_req/addr/data       pulse + operands: start a single write
//   o_busy                   transaction in progress (requests ignored)
//   o_valid                  one-cycle pulse: snapshot outputs updated
//   o_wr_done                one-cycle pulse: write acknowledged
//   o_err                    one-cycle pulse: timeout abort
//   o_wb_*                   Wishbone initiator controls / address / write data
//   i_wb_stall/ack/data      Wishbone slave responses
//   o_clock..o_ckspeed       registers 0..4 of the last valid snapshot
//   o_dbg_state              current FSM state (0 idle, 1 write, 2 read)
//
// Handshake: a request is accepted on a cycle where cyc && stb && !stall; the
// slave answers each accepted request with exactly one ack, in order, with read
// data valid in the ack cycle. An ack may coincide with the acceptance cycle.
// Acks seen while cyc is low are ignored.

module rtc_snapshot_master #(
  parameter int TIMEOUT = 16,
  parameter int NREGS   = 5
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_snap,
  input  logic        i_wr_req,
  input  logic [2:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_wr_done,
  output logic        o_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_clock,
  output logic [31:0] o_timer,
  output logic [31:0] o_stopwatch,
  output logic [31:0] o_alarm,
  output logic [31:0] o_ckspeed,
`ifdef RTCSNAP_HACK_EN
  output logic [29:0] o_hack_time,
  output logic [39:0] o_hack_counter,
`endif
  output logic [1:0]  o_dbg_state
);

`ifdef RTCSNAP_HACK_EN
  localparam int NR = 8;
`else
  localparam int NR = NREGS;
`endif
  localparam int AW = $clog2(NR) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0]    LAST_ADDR = 3'(NR - 1);
  localparam logic [AW-1:0] LAST_ACK  = AW'(NR - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [2:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            busy_d, valid_d, done_d, err_d;
  logic [AW-1:0]   ackcnt_q, ackcnt_d;
  logic [TW-1:0]   tocnt_q, tocnt_d;
  logic [31:0]     shadow_q [NR];
  logic [31:0]     shadow_d [NR];
  logic [31:0]     snap_q [NR];
  logic [31:0]     snap_d [NR];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 3'd0;
      wdata_q   <= 32'd0;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_wr_done <= 1'b0;
      o_err     <= 1'b0;
      ackcnt_q  <= '0;
      tocnt_q   <= '0;
      for (int i = 0; i < NR; i++) begin
        shadow_q[i] <= 32'd0;
        snap_q[i]   <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      o_busy    <= busy_d;
      o_valid   <= valid_d;
      o_wr_done <= done_d;
      o_err     <= err_d;
      ackcnt_q  <= ackcnt_d;
      tocnt_q   <= tocnt_d;
      for (int i = 0; i < NR; i++) begin
        shadow_q[i] <= shadow_d[i];
        snap_q[i]   <= snap_d[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ackcnt_d = ackcnt_q;
    tocnt_d  = tocnt_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      shadow_d[i] = shadow_q[i];
      snap_d[i]   = snap_q[i];
    end

    unique case (state_q)
      S_IDLE: begin
        // Write wins over a simultaneous snapshot request; the snapshot is dropped.
        if (i_wr_req) begin
          state_d = S_WRITE;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = i_wr_addr;
          wdata_d = i_wr_data;
          tocnt_d = '0;
        end else if (i_snap) begin
          state_d  = S_READ;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = 3'd0;
          ackcnt_d = '0;
          tocnt_d  = '0;
        end
      end

      S_WRITE: begin
        if (stb_q && !i_wb_stall) stb_d = 1'b0;
        if (i_wb_ack) begin
          state_d = S_IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          tocnt_d = '0;
          done_d  = 1'b1;
        end else if (tocnt_q == TO_LAST) begin
          state_d = S_IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          tocnt_d = tocnt_q + TW'(1);
        end
      end

      S_READ: begin
        // Address stops at the last register, so it never leaves 0..NR-1.
        if (stb_q && !i_wb_stall) begin
          if (addr_q == LAST_ADDR) stb_d = 1'b0;
          else                     addr_d = addr_q + 3'd1;
        end
        if (i_wb_ack) begin
          for (int i = 0; i < NR; i++) begin
            if (ackcnt_q == AW'(i)) shadow_d[i] = i_wb_data;
          end
          ackcnt_d = ackcnt_q + AW'(1);
          tocnt_d  = '0;
          if (ackcnt_q == LAST_ACK) begin
            // Final ack: publish the whole shadow (including this word) at once.
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            valid_d = 1'b1;
            for (int i = 0; i < NR; i++) snap_d[i] = shadow_d[i];
          end
        end else if (tocnt_q == TO_LAST) begin
          // Partial shadow is abandoned; published outputs stay as they were.
          state_d = S_IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          tocnt_d = tocnt_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = wdata_q;
  assign o_clock     = snap_q[0];
  assign o_timer     = snap_q[1];
  assign o_stopwatch = snap_q[2];
  assign o_alarm     = snap_q[3];
  assign o_ckspeed   = snap_q[4];
  assign o_dbg_state = state_q;
`ifdef RTCSNAP_HACK_EN
  assign o_hack_time    = snap_q[5][29:0];
  assign o_hack_counter = {snap_q[6], snap_q[7][31:24]};
`endif

endmodule

// File: tb/tb_rtc_snapshot_master.sv
// Testbench for rtc_snapshot_master: a Wishbone slave model with programmable
// stall/ack behaviour, a register-file reference model of the RTC contents,
// directed scenarios and a randomized write/snapshot loop.

module tb_rtc_snapshot_master;

`ifdef RTCSNAP_HACK_EN
  localparam int N = 8;
`else
  localparam int N = 5;
`endif
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_snap = 1'b0, i_wr_req = 1'b0;
  logic [2:0]  i_wr_addr = 3'd0;
  logic [31:0] i_wr_data = 32'd0;
  logic        o_busy, o_valid, o_wr_done, o_err;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_stall = 1'b0, i_wb_ack = 1'b0;
  logic [31:0] i_wb_data = 32'd0;
  logic [31:0] o_clock, o_timer, o_stopwatch, o_alarm, o_ckspeed;
  logic [1:0]  o_dbg_state;
`ifdef RTCSNAP_HACK_EN
  logic [29:0] o_hack_time;
  logic [39:0] o_hack_counter;
`endif

  rtc_snapshot_master #(.TIMEOUT(TO), .NREGS(5)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_snap(i_snap), .i_wr_req(i_wr_req),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_busy(o_busy), .o_valid(o_valid),
    .o_wr_done(o_wr_done), .o_err(o_err), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
    .o_clock(o_clock), .o_timer(o_timer), .o_stopwatch(o_stopwatch),
    .o_alarm(o_alarm), .o_ckspeed(o_ckspeed),
`ifdef RTCSNAP_HACK_EN
    .o_hack_time(o_hack_time), .o_hack_counter(o_hack_counter),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0, bad = 0;
  logic [31:0] model_mem [8];   // what the RTC registers hold, per issued writes
  logic [31:0] slave_mem [8];   // the slave's own register file
  logic [2:0]  exp_q [$];       // expected read-address order
  logic [2:0]  acc_q [$];       // observed accepted read addresses

  // ---------------- slave model + monitor (negedge) ----------------
  int  cyc_num = 0;
  bit  ack_en = 1'b1, rand_stall = 1'b0, pend = 1'b0;
  logic [2:0] pend_addr = 3'd0;
  int  stall_addr = -1, stall_left = 0;
  int  cyc_hi_cnt, valid_cnt, err_cnt, done_cnt, rd_acc_cnt, wr_acc_cnt;
  int  held_cnt, oob_cnt, ack_in_cyc, stb_we_cnt;
  int  valid_cyc, done_cyc, wr_acc_cyc, req_cyc;
  logic [2:0]  wr_acc_addr;
  logic [31:0] wr_acc_data;

  always @(negedge i_clk) begin
    cyc_num++;
    // One-cycle ack latency after acceptance; read data valid with ack.
    if (pend && ack_en) begin
      i_wb_ack  = 1'b1;
      i_wb_data = slave_mem[pend_addr];
    end else begin
      i_wb_ack  = 1'b0;
      i_wb_data = $urandom;
    end
    pend = 1'b0;
    if (o_wb_cyc && o_wb_stb && stall_left > 0 && int'(o_wb_addr) == stall_addr) begin
      i_wb_stall = 1'b1;
      stall_left--;
      held_cnt++;
    end else if (rand_stall) begin
      i_wb_stall = ($urandom_range(0, 3) == 0);
    end else begin
      i_wb_stall = 1'b0;
    end
    if (o_wb_cyc) begin
      cyc_hi_cnt++;
      if (!o_wb_we && int'(o_wb_addr) >= N) oob_cnt++;
      if (i_wb_ack) ack_in_cyc++;
    end
    if (o_wb_cyc && o_wb_stb && o_wb_we) stb_we_cnt++;
    if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
      pend      = 1'b1;
      pend_addr = o_wb_addr;
      if (o_wb_we) begin
        wr_acc_cnt++;
        wr_acc_addr = o_wb_addr;
        wr_acc_data = o_wb_data;
        wr_acc_cyc  = cyc_num;
        slave_mem[o_wb_addr] = o_wb_data;
      end else begin
        rd_acc_cnt++;
        acc_q.push_back(o_wb_addr);
      end
    end
    if (o_valid)   begin valid_cnt++; valid_cyc = cyc_num; end
    if (o_wr_done) begin done_cnt++;  done_cyc  = cyc_num; end
    if (o_err)     err_cnt++;
  end

  // ---------------- checking + driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cyc_hi_cnt = 0; valid_cnt = 0; err_cnt = 0; done_cnt = 0; rd_acc_cnt = 0;
    wr_acc_cnt = 0; held_cnt = 0; oob_cnt = 0; ack_in_cyc = 0; stb_we_cnt = 0;
    valid_cyc = 0; done_cyc = 0; wr_acc_cyc = 0;
    acc_q.delete();
    exp_q.delete();
  endtask

  task automatic do_snap();
    i_snap  = 1'b1;
    req_cyc = cyc_num + 1;
    for (int a = 0; a < N; a++) exp_q.push_back(3'(a));
    @(posedge i_clk); #1;
    i_snap = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    i_wr_req  = 1'b1;
    i_wr_addr = a;
    i_wr_data = d;
    model_mem[a] = d;
    @(posedge i_clk); #1;
    i_wr_req  = 1'b0;
    i_wr_data = $urandom;
  endtask

  task automatic finish_txn(input string tag);
    int n = 0;
    while (o_busy && n < 300) begin
      @(posedge i_clk); #1;
      n++;
    end
    check({tag, "_idle"}, o_busy, 0);
    repeat (2) begin @(posedge i_clk); #1; end
  endtask

  task automatic check_snap(input string tag);
    check({tag, "_clock"},     o_clock,     model_mem[0]);
    check({tag, "_timer"},     o_timer,     model_mem[1]);
    check({tag, "_stopwatch"}, o_stopwatch, model_mem[2]);
    check({tag, "_alarm"},     o_alarm,     model_mem[3]);
    check({tag, "_ckspeed"},   o_ckspeed,   model_mem[4]);
`ifdef RTCSNAP_HACK_EN
    check({tag, "_hack_time"}, o_hack_time, model_mem[5][29:0]);
    check({tag, "_hack_cnt"},  o_hack_counter, {model_mem[6], model_mem[7][31:24]});
`endif
  endtask

  task automatic check_addr_seq(input string tag);
    check({tag, "_nacc"}, acc_q.size(), exp_q.size());
    while (acc_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_addr"}, acc_q.pop_front(), exp_q.pop_front());
    check({tag, "_oob"}, oob_cnt, 0);
  endtask

  task automatic check_snap_txn(input string tag);
    check({tag, "_valid"}, valid_cnt, 1);
    check({tag, "_err"},   err_cnt,   0);
    check_addr_seq(tag);
    check_snap(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int a = 0; a < 8; a++) begin
      model_mem[a] = 32'h11 * (a + 1);
      slave_mem[a] = 32'h11 * (a + 1);
    end
    clear_mon();

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_we", o_wb_we, 0);
    check("rst_addr", o_wb_addr, 0);
    check("rst_wdata", o_wb_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_pulses", {o_valid, o_wr_done, o_err}, 0);
    check("rst_clock", o_clock, 0);
    check("rst_ckspeed", o_ckspeed, 0);
    check("rst_state", o_dbg_state, 0);
    i_reset_n = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end

    // Snapshot, zero-wait slave: latency NREGS+2
    clear_mon();
    do_snap();
    check("snap_busy", o_busy, 1);
    finish_txn("snap");
    check("snap_latency", valid_cyc - req_cyc, N + 2);
    check("snap_cycles", cyc_hi_cnt, N + 1);
    check_snap_txn("snap");

    // Snapshot with a 3-cycle stall while addr 2 is presented
    clear_mon();
    stall_addr = 2; stall_left = 3;
    do_snap();
    finish_txn("stall");
    check("stall_held", held_cnt, 3);
    check_snap_txn("stall");
    stall_addr = -1;

    // Single write: one stb cycle, wr_done two cycles after it
    clear_mon();
    do_write(3'd0, 32'h0012_3456);
    finish_txn("wr");
    check("wr_stb_cycles", stb_we_cnt, 1);
    check("wr_nacc", wr_acc_cnt, 1);
    check("wr_addr", wr_acc_addr, 0);
    check("wr_data", wr_acc_data, 32'h0012_3456);
    check("wr_done_cnt", done_cnt, 1);
    check("wr_done_lat", done_cyc - wr_acc_cyc, 2);
    check("wr_no_valid", valid_cnt, 0);

    clear_mon();
    do_snap();
    finish_txn("post_wr");
    check_snap_txn("post_wr");

    // Timeout: slave never acks
    clear_mon();
    ack_en = 1'b0;
    do_snap();
    finish_txn("tmo");
    ack_en = 1'b1;
    check("tmo_cyc_cycles", cyc_hi_cnt, TO);
    check("tmo_err", err_cnt, 1);
    check("tmo_valid", valid_cnt, 0);
    check_snap("tmo");

    // Simultaneous snap + write, then snap while busy: only the write runs
    clear_mon();
    stall_addr = 3; stall_left = 3;
    i_snap = 1'b1;
    do_write(3'd3, 32'hCAFE_0003);
    i_snap = 1'b0;
    @(posedge i_clk); #1;
    check("simul_busy", o_busy, 1);
    i_snap = 1'b1;
    @(posedge i_clk); #1;
    i_snap = 1'b0;
    finish_txn("simul");
    stall_addr = -1;
    check("simul_rd_acc", rd_acc_cnt, 0);
    check("simul_wr_acc", wr_acc_cnt, 1);
    check("simul_valid", valid_cnt, 0);
    check("simul_done", done_cnt, 1);

    // Reset during a read after two acks
    clear_mon();
    do_snap();
    for (int i = 0; i < 50 && ack_in_cyc < 2; i++) begin @(posedge i_clk); #1; end
    check("rstrd_acks", ack_in_cyc, 2);
    i_reset_n = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("rstrd_cyc", o_wb_cyc, 0);
    check("rstrd_busy", o_busy, 0);
    check("rstrd_clock", o_clock, 0);
    check("rstrd_ckspeed", o_ckspeed, 0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    repeat (3) begin @(posedge i_clk); #1; end
    check("rstrd_valid", valid_cnt, 0);
    check("rstrd_err", err_cnt, 0);
    clear_mon();
    do_snap();
    finish_txn("rstrd_snap");
    check_snap_txn("rstrd_snap");

    // Randomized writes and snapshots against the register model
    for (int it = 0; it < 40; it++) begin
      logic [2:0]  a;
      logic [31:0] d;
      clear_mon();
      rand_stall = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        a = 3'($urandom_range(0, N - 1));
        d = $urandom;
        do_write(a, d);
        finish_txn("rnd_wr");
        check("rnd_wr_done", done_cnt, 1);
        check("rnd_wr_addr", wr_acc_addr, a);
        check("rnd_wr_data", wr_acc_data, d);
      end else begin
        do_snap();
        finish_txn("rnd_snap");
        check_snap_txn("rnd_snap");
      end
    end
    rand_stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
